// File: rtl/id_ex_pipe_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_pipe_reg_if
// Brief    : Decode-to-execute bundle for the ID/EX pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
interface id_ex_pipe_reg_if #(
    parameter int DATA_W = 8,
    parameter int IMM_W  = 8,
    parameter int REG_W  = 1,
    parameter int WB_W   = 2,
    parameter int M_W    = 2,
    parameter int EX_W   = 2,
    parameter int CNT_W  = 8
);
    // Decode side
    logic              hold;
    logic              flush;
    logic [WB_W-1:0]   WB;
    logic [M_W-1:0]    M;
    logic [EX_W-1:0]   EX;
    logic [DATA_W-1:0] DataA;
    logic [DATA_W-1:0] DataB;
    logic [IMM_W-1:0]  imm_value;
    logic [REG_W-1:0]  RegRs;
    logic [REG_W-1:0]  RegRt;

    // Execute side
    logic [WB_W-1:0]   WBreg;
    logic [M_W-1:0]    Mreg;
    logic [EX_W-1:0]   EXreg;
    logic [DATA_W-1:0] DataAreg;
    logic [DATA_W-1:0] DataBreg;
    logic [IMM_W-1:0]  imm_valuereg;
    logic [REG_W-1:0]  RegRsreg;
    logic [REG_W-1:0]  RegRtreg;
    logic              validreg;
    logic              hazard_stall;
    logic [CNT_W-1:0]  bubble_count;

    modport master (
        output hold, flush, WB, M, EX, DataA, DataB, imm_value, RegRs, RegRt,
        input  WBreg, Mreg, EXreg, DataAreg, DataBreg, imm_valuereg,
               RegRsreg, RegRtreg, validreg, hazard_stall, bubble_count
    );

    modport slave (
        input  hold, flush, WB, M, EX, DataA, DataB, imm_value, RegRs, RegRt,
        output WBreg, Mreg, EXreg, DataAreg, DataBreg, imm_valuereg,
               RegRsreg, RegRtreg, validreg, hazard_stall, bubble_count
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_pipe_reg
// Brief    : ID/EX pipeline register with hold, flush and load-use bubbles.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_pipe_reg #(
    parameter int DATA_W      = 8,
    parameter int IMM_W       = 8,
    parameter int REG_W       = 1,
    parameter int WB_W        = 2,
    parameter int M_W         = 2,
    parameter int EX_W        = 2,
    parameter int MEMREAD_BIT = 0,
    parameter int HAZARD_EN   = 1,
    parameter int CNT_W       = 8
) (
    input  wire logic        clock,
    input  wire logic        reset,
    id_ex_pipe_reg_if.slave  bus
);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [WB_W-1:0]   r_wb;
    logic [M_W-1:0]    r_m;
    logic [EX_W-1:0]   r_ex;
    logic [DATA_W-1:0] r_data_a;
    logic [DATA_W-1:0] r_data_b;
    logic [IMM_W-1:0]  r_imm;
    logic [REG_W-1:0]  r_rs;
    logic [REG_W-1:0]  r_rt;
    logic              r_valid;
    logic [CNT_W-1:0]  r_bubble_cnt;

    logic              w_hazard_raw;
    logic              w_bubble;
    logic [CNT_W-1:0]  w_cnt_next;

    // A load sitting in EX whose destination is read by the instruction in ID
    generate
        if (HAZARD_EN != 0) begin : g_hazard
            assign w_hazard_raw = r_valid & r_m[MEMREAD_BIT] &
                                  ((r_rt == bus.RegRs) | (r_rt == bus.RegRt));
        end else begin : g_no_hazard
            assign w_hazard_raw = 1'b0;
        end
    endgenerate

    // Flush overrides hold; hold overrides a hazard bubble
    assign w_bubble   = bus.flush | (~bus.hold & w_hazard_raw);
    assign w_cnt_next = (r_bubble_cnt == c_CNT_MAX) ? r_bubble_cnt
                                                    : r_bubble_cnt + c_CNT_ONE;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wb         <= '0;
            r_m          <= '0;
            r_ex         <= '0;
            r_data_a     <= '0;
            r_data_b     <= '0;
            r_imm        <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_valid      <= 1'b0;
            r_bubble_cnt <= '0;
        end else if (w_bubble) begin
            // Operand fields keep their old value; only control is squashed
            r_wb         <= '0;
            r_m          <= '0;
            r_ex         <= '0;
            r_valid      <= 1'b0;
            r_bubble_cnt <= w_cnt_next;
        end else if (!bus.hold) begin
            r_wb         <= bus.WB;
            r_m          <= bus.M;
            r_ex         <= bus.EX;
            r_data_a     <= bus.DataA;
            r_data_b     <= bus.DataB;
            r_imm        <= bus.imm_value;
            r_rs         <= bus.RegRs;
            r_rt         <= bus.RegRt;
            r_valid      <= 1'b1;
        end
    end

    assign bus.WBreg        = r_wb;
    assign bus.Mreg         = r_m;
    assign bus.EXreg        = r_ex;
    assign bus.DataAreg     = r_data_a;
    assign bus.DataBreg     = r_data_b;
    assign bus.imm_valuereg = r_imm;
    assign bus.RegRsreg     = r_rs;
    assign bus.RegRtreg     = r_rt;
    assign bus.validreg     = r_valid;
    assign bus.bubble_count = r_bubble_cnt;
    assign bus.hazard_stall = w_hazard_raw & ~bus.flush;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_pipe_reg
// Brief    : Directed and random checks of three id_ex_pipe_reg configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_pipe_reg;
    logic       clock;
    logic       reset;
    logic       hold, flush;
    logic [1:0] wb, m, ex;
    logic [7:0] a, b, imm;
    logic       rs, rt;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [1:0] wb, m, ex;
        logic [7:0] a, b, imm;
        logic       rs, rt, v;
        logic [7:0] cnt;
    } st_t;

    // index 0: default, 1: CNT_W=2, 2: HAZARD_EN=0
    st_t mdl [3];
    int  HEN  [3] = '{1, 1, 0};
    int  CMAX [3] = '{255, 3, 255};

    id_ex_pipe_reg_if                 if0 ();
    id_ex_pipe_reg_if #(.CNT_W(2))    if_sat ();
    id_ex_pipe_reg_if                 if_nh ();

    id_ex_pipe_reg                       u_dut   (.clock(clock), .reset(reset), .bus(if0));
    id_ex_pipe_reg #(.CNT_W(2))          u_sat   (.clock(clock), .reset(reset), .bus(if_sat));
    id_ex_pipe_reg #(.HAZARD_EN(0))      u_nohaz (.clock(clock), .reset(reset), .bus(if_nh));

    assign if0.hold = hold;       assign if_sat.hold = hold;       assign if_nh.hold = hold;
    assign if0.flush = flush;     assign if_sat.flush = flush;     assign if_nh.flush = flush;
    assign if0.WB = wb;           assign if_sat.WB = wb;           assign if_nh.WB = wb;
    assign if0.M = m;             assign if_sat.M = m;             assign if_nh.M = m;
    assign if0.EX = ex;           assign if_sat.EX = ex;           assign if_nh.EX = ex;
    assign if0.DataA = a;         assign if_sat.DataA = a;         assign if_nh.DataA = a;
    assign if0.DataB = b;         assign if_sat.DataB = b;         assign if_nh.DataB = b;
    assign if0.imm_value = imm;   assign if_sat.imm_value = imm;   assign if_nh.imm_value = imm;
    assign if0.RegRs = rs;        assign if_sat.RegRs = rs;        assign if_nh.RegRs = rs;
    assign if0.RegRt = rt;        assign if_sat.RegRt = rt;        assign if_nh.RegRt = rt;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic haz(int k);
        return (HEN[k] != 0) && mdl[k].v && mdl[k].m[0] &&
               (mdl[k].rt == rs || mdl[k].rt == rt);
    endfunction

    function automatic st_t obs_st(int k);
        st_t s;
        case (k)
            0: s = '{if0.WBreg, if0.Mreg, if0.EXreg, if0.DataAreg, if0.DataBreg,
                     if0.imm_valuereg, if0.RegRsreg, if0.RegRtreg, if0.validreg,
                     if0.bubble_count};
            1: s = '{if_sat.WBreg, if_sat.Mreg, if_sat.EXreg, if_sat.DataAreg, if_sat.DataBreg,
                     if_sat.imm_valuereg, if_sat.RegRsreg, if_sat.RegRtreg, if_sat.validreg,
                     {6'b0, if_sat.bubble_count}};
            default: s = '{if_nh.WBreg, if_nh.Mreg, if_nh.EXreg, if_nh.DataAreg, if_nh.DataBreg,
                     if_nh.imm_valuereg, if_nh.RegRsreg, if_nh.RegRtreg, if_nh.validreg,
                     if_nh.bubble_count};
        endcase
        return s;
    endfunction

    function automatic logic obs_hs(int k);
        case (k)
            0:       return if0.hazard_stall;
            1:       return if_sat.hazard_stall;
            default: return if_nh.hazard_stall;
        endcase
    endfunction

    // Pipeline register behaviour stated as a priority table
    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                mdl[k] = '0;
            end else if (flush || (!hold && haz(k))) begin
                mdl[k].wb = 0; mdl[k].m = 0; mdl[k].ex = 0; mdl[k].v = 0;
                if (int'(mdl[k].cnt) < CMAX[k]) mdl[k].cnt = mdl[k].cnt + 8'd1;
            end else if (!hold) begin
                mdl[k].wb = wb; mdl[k].m = m; mdl[k].ex = ex;
                mdl[k].a = a; mdl[k].b = b; mdl[k].imm = imm;
                mdl[k].rs = rs; mdl[k].rt = rt; mdl[k].v = 1'b1;
            end
        end
    endtask

    task automatic tick();
        #1;
        for (int k = 0; k < 3; k++)
            chk($sformatf("hazard_stall[%0d]", k), 64'(obs_hs(k)), 64'(haz(k) && !flush));
        @(posedge clock);
        model_edge();
        #1;
        for (int k = 0; k < 3; k++)
            chk($sformatf("regs[%0d]", k), 64'(obs_st(k)), 64'(mdl[k]));
    endtask

    task automatic set_in(input logic [1:0] iwb, im, iex, input logic [7:0] ia, ib, iimm,
                          input logic irs, irt);
        wb = iwb; m = im; ex = iex; a = ia; b = ib; imm = iimm; rs = irs; rt = irt;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) mdl[k] = '0;
        // T1: reset with nonzero inputs for two edges
        reset = 1'b1; hold = 1'b0; flush = 1'b0;
        set_in(2'b11, 2'b11, 2'b11, 8'hFF, 8'hEE, 8'hDD, 1'b1, 1'b1);
        @(posedge clock);
        model_edge();
        #1;
        tick();
        chk("t1_datab", 64'(if0.DataBreg), 64'h0);
        chk("t1_count", 64'(if0.bubble_count), 64'h0);
        chk("t1_valid", 64'(if0.validreg), 64'h0);

        // T2: pass-through
        reset = 1'b0;
        set_in(2'b10, 2'b00, 2'b01, 8'h3C, 8'hA5, 8'h7F, 1'b0, 1'b1);
        tick();
        chk("t2_wb", 64'(if0.WBreg), 64'h2);
        chk("t2_ex", 64'(if0.EXreg), 64'h1);
        chk("t2_datab", 64'(if0.DataBreg), 64'hA5);
        chk("t2_imm", 64'(if0.imm_valuereg), 64'h7F);
        chk("t2_valid", 64'(if0.validreg), 64'h1);

        // T3: load-use hazard
        set_in(2'b01, 2'b01, 2'b00, 8'h01, 8'h02, 8'h03, 1'b0, 1'b1);
        tick();
        set_in(2'b10, 2'b00, 2'b11, 8'h44, 8'h55, 8'h66, 1'b1, 1'b0);
        #1;
        chk("t3_stall", 64'(if0.hazard_stall), 64'h1);
        chk("t3_nohaz_stall", 64'(if_nh.hazard_stall), 64'h0);
        tick();
        chk("t3_bubble_valid", 64'(if0.validreg), 64'h0);
        chk("t3_bubble_m", 64'(if0.Mreg), 64'h0);
        chk("t3_bubble_cnt", 64'(if0.bubble_count), 64'h1);
        chk("t3_nohaz_load", 64'(if_nh.DataAreg), 64'h44);
        tick();
        chk("t3_after_valid", 64'(if0.validreg), 64'h1);
        chk("t3_after_data", 64'(if0.DataAreg), 64'h44);

        // T4: hold
        set_in(2'b00, 2'b00, 2'b00, 8'h11, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        hold = 1'b1; a = 8'h22;
        repeat (3) tick();
        chk("t4_held_a", 64'(if0.DataAreg), 64'h11);
        chk("t4_held_cnt", 64'(if0.bubble_count), 64'h1);
        hold = 1'b0;
        tick();
        chk("t4_release_a", 64'(if0.DataAreg), 64'h22);

        // T5: flush with hold, then flush during a hazard
        set_in(2'b11, 2'b10, 2'b11, 8'h77, 8'h88, 8'h99, 1'b0, 1'b0);
        flush = 1'b1; hold = 1'b1;
        tick();
        chk("t5_fh_wb", 64'(if0.WBreg), 64'h0);
        chk("t5_fh_cnt", 64'(if0.bubble_count), 64'h2);
        flush = 1'b0; hold = 1'b0;
        set_in(2'b01, 2'b01, 2'b00, 8'h10, 8'h20, 8'h30, 1'b0, 1'b1);
        tick();
        rs = 1'b1; rt = 1'b0; flush = 1'b1;
        #1;
        chk("t5_flush_stall", 64'(if0.hazard_stall), 64'h0);
        tick();
        chk("t5_flush_cnt", 64'(if0.bubble_count), 64'h3);
        chk("t5_flush_valid", 64'(if0.validreg), 64'h0);

        // T6: saturation, then reset
        repeat (5) tick();
        chk("t6_sat", 64'(if_sat.bubble_count), 64'h3);
        chk("t6_wide", 64'(if0.bubble_count), 64'h8);
        flush = 1'b0; reset = 1'b1;
        tick();
        chk("t6_reset_cnt", 64'(if_sat.bubble_count), 64'h0);
        reset = 1'b0;

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 99) < 2);
            flush = ($urandom_range(0, 7) == 0);
            hold  = ($urandom_range(0, 5) == 0);
            set_in(2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom),
                   8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
